// File: rtl/reorder_buffer_pkg.sv
// reorder_buffer_pkg: shared encodings, widths and entry layout for the reorder buffer
package reorder_buffer_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {
    ROB_TYPE_REG    = 2'd0,
    ROB_TYPE_STORE  = 2'd1,
    ROB_TYPE_BRANCH = 2'd2,
    ROB_TYPE_HALT   = 2'd3
  } rob_type_e;
  typedef struct packed {
    logic                  valid;
    logic                  ready;
    rob_type_e             kind;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       pc;
    logic                  pred;
    logic [XLEN-1:0]       value;
    logic                  taken;
    logic [XLEN-1:0]       target;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: issue, writeback, query, commit and flush signals of the reorder buffer
interface reorder_buffer_if #(parameter int ROB_WIDTH = 4);
  import reorder_buffer_pkg::*;
  logic                  readyIn;
  logic                  issueValid;
  logic [1:0]            issueType;
  logic [REG_ADDR_W-1:0] issueRd;
  logic [XLEN-1:0]       issuePc;
  logic                  issuePredTaken;
  logic [ROB_WIDTH-1:0]  issueId;
  logic                  robFull;
  logic                  cdbValid;
  logic [ROB_WIDTH-1:0]  cdbId;
  logic [XLEN-1:0]       cdbValue;
  logic                  cdbTaken;
  logic [XLEN-1:0]       cdbTarget;
  logic                  lsbValid;
  logic [ROB_WIDTH-1:0]  lsbId;
  logic [XLEN-1:0]       lsbValue;
  logic [ROB_WIDTH-1:0]  query1Id, query2Id;
  logic                  query1Ready, query2Ready;
  logic [XLEN-1:0]       query1Value, query2Value;
  logic                  commitFlag;
  logic [ROB_WIDTH-1:0]  commitId;
  logic [REG_ADDR_W-1:0] commitAddr;
  logic [XLEN-1:0]       commitValue;
  logic                  storeCommit;
  logic [ROB_WIDTH-1:0]  storeId;
  logic                  clearOut;
  logic [XLEN-1:0]       redirectPc;
  logic                  bpUpdate;
  logic [XLEN-1:0]       bpPc;
  logic                  bpTaken;
  logic                  haltOut;
  modport master (
    output readyIn, issueValid, issueType, issueRd, issuePc, issuePredTaken,
    output cdbValid, cdbId, cdbValue, cdbTaken, cdbTarget, lsbValid, lsbId, lsbValue,
    output query1Id, query2Id,
    input  issueId, robFull, query1Ready, query2Ready, query1Value, query2Value,
    input  commitFlag, commitId, commitAddr, commitValue, storeCommit, storeId,
    input  clearOut, redirectPc, bpUpdate, bpPc, bpTaken, haltOut
  );
  modport slave (
    input  readyIn, issueValid, issueType, issueRd, issuePc, issuePredTaken,
    input  cdbValid, cdbId, cdbValue, cdbTaken, cdbTarget, lsbValid, lsbId, lsbValue,
    input  query1Id, query2Id,
    output issueId, robFull, query1Ready, query2Ready, query1Value, query2Value,
    output commitFlag, commitId, commitAddr, commitValue, storeCommit, storeId,
    output clearOut, redirectPc, bpUpdate, bpPc, bpTaken, haltOut
  );
endinterface

// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order commit queue with result capture, operand bypass and mispredict flush
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int ROB_WIDTH = 4
) (
  input logic        clockIn,
  input logic        resetIn,
  reorder_buffer_if.slave rob
);
  localparam int DEPTH = 2 ** ROB_WIDTH;
  typedef logic [ROB_WIDTH-1:0] id_t;
  typedef logic [ROB_WIDTH:0] cnt_t;
  typedef struct packed {
    logic                  commit_flag;
    id_t                   commit_id;
    logic [REG_ADDR_W-1:0] commit_addr;
    logic [XLEN-1:0]       commit_value;
    logic                  store_commit;
    id_t                   store_id;
    logic                  clear;
    logic [XLEN-1:0]       redirect_pc;
    logic                  bp_update;
    logic [XLEN-1:0]       bp_pc;
    logic                  bp_taken;
  } out_t;
  rob_entry_t ent_q [DEPTH];
  rob_entry_t ent_d [DEPTH];
  rob_entry_t head_e;
  id_t head_q, head_d, tail_q, tail_d;
  cnt_t count_q, count_d;
  logic halt_q, halt_d;
  out_t out_q, out_d;
  logic full, do_issue, do_commit, mispredict, is_wr, cdb_hit1, cdb_hit2, lsb_hit1, lsb_hit2;
  // full is taken from the pre-commit count, so a commit never frees space for a same-cycle issue
  always_comb begin
    head_e = ent_q[head_q];
    full = count_q == cnt_t'(DEPTH);
    do_issue = rob.issueValid & !full & rob.readyIn;
    do_commit = rob.readyIn & (count_q != '0) & head_e.ready & !halt_q;
    is_wr = head_e.kind == ROB_TYPE_REG || head_e.kind == ROB_TYPE_BRANCH;
    mispredict = do_commit & head_e.kind == ROB_TYPE_BRANCH & (head_e.taken != head_e.pred);
  end
  // operand lookup: bus bypass wins over the stored value
  always_comb begin
    cdb_hit1 = rob.cdbValid && rob.cdbId == rob.query1Id;
    lsb_hit1 = rob.lsbValid && rob.lsbId == rob.query1Id;
    cdb_hit2 = rob.cdbValid && rob.cdbId == rob.query2Id;
    lsb_hit2 = rob.lsbValid && rob.lsbId == rob.query2Id;
    rob.query1Ready = cdb_hit1 | lsb_hit1 | ent_q[rob.query1Id].ready;
    rob.query2Ready = cdb_hit2 | lsb_hit2 | ent_q[rob.query2Id].ready;
    rob.query1Value = cdb_hit1 ? rob.cdbValue : lsb_hit1 ? rob.lsbValue : ent_q[rob.query1Id].value;
    rob.query2Value = cdb_hit2 ? rob.cdbValue : lsb_hit2 ? rob.lsbValue : ent_q[rob.query2Id].value;
  end
  // next state: writeback, issue at tail, retire at head, then a flush overrides everything
  always_comb begin
    ent_d = ent_q;
    head_d = head_q;
    tail_d = tail_q + id_t'(do_issue);
    count_d = count_q + cnt_t'(do_issue) - cnt_t'(do_commit);
    halt_d = halt_q | (do_commit & head_e.kind == ROB_TYPE_HALT);
    out_d = '0;
    if (rob.readyIn && rob.cdbValid && ent_q[rob.cdbId].valid) begin
      ent_d[rob.cdbId].ready = 1'b1;
      ent_d[rob.cdbId].value = rob.cdbValue;
      ent_d[rob.cdbId].taken = rob.cdbTaken;
      ent_d[rob.cdbId].target = rob.cdbTarget;
    end
    if (rob.readyIn && rob.lsbValid && ent_q[rob.lsbId].valid) begin
      ent_d[rob.lsbId].ready = 1'b1;
      ent_d[rob.lsbId].value = rob.lsbValue;
    end
    if (do_issue)
      ent_d[tail_q] = '{valid: 1'b1, ready: 1'b0, kind: rob_type_e'(rob.issueType), rd: rob.issueRd,
                        pc: rob.issuePc, pred: rob.issuePredTaken, value: '0, taken: 1'b0, target: '0};
    if (do_commit) begin
      ent_d[head_q].valid = 1'b0;
      ent_d[head_q].ready = 1'b0;
      head_d = head_q + 1'b1;
      out_d.commit_flag = is_wr & (head_e.rd != '0);
      out_d.commit_id = is_wr ? head_q : '0;
      out_d.commit_addr = is_wr ? head_e.rd : '0;
      out_d.commit_value = is_wr ? head_e.value : '0;
      out_d.store_commit = head_e.kind == ROB_TYPE_STORE;
      out_d.store_id = head_e.kind == ROB_TYPE_STORE ? head_q : '0;
      out_d.bp_update = head_e.kind == ROB_TYPE_BRANCH;
      out_d.bp_pc = head_e.kind == ROB_TYPE_BRANCH ? head_e.pc : '0;
      out_d.bp_taken = head_e.kind == ROB_TYPE_BRANCH & head_e.taken;
      out_d.clear = mispredict;
      out_d.redirect_pc = mispredict ? head_e.target : '0;
    end
    if (mispredict) begin
      for (int i = 0; i < DEPTH; i++) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].ready = 1'b0;
      end
      head_d = '0;
      tail_d = '0;
      count_d = '0;
    end
  end
  // state and registered commit-side outputs
  always_ff @(posedge clockIn or negedge resetIn) begin
    if (!resetIn) begin
      ent_q <= '{default: '0};
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      halt_q <= 1'b0;
      out_q <= '0;
    end else begin
      ent_q <= ent_d;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      halt_q <= halt_d;
      out_q <= out_d;
    end
  end
  assign rob.issueId = tail_q;
  assign rob.robFull = full;
  assign rob.commitFlag = out_q.commit_flag;
  assign rob.commitId = out_q.commit_id;
  assign rob.commitAddr = out_q.commit_addr;
  assign rob.commitValue = out_q.commit_value;
  assign rob.storeCommit = out_q.store_commit;
  assign rob.storeId = out_q.store_id;
  assign rob.clearOut = out_q.clear;
  assign rob.redirectPc = out_q.redirect_pc;
  assign rob.bpUpdate = out_q.bp_update;
  assign rob.bpPc = out_q.bp_pc;
  assign rob.bpTaken = out_q.bp_taken;
  assign rob.haltOut = halt_q;
endmodule
